// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO registers: one product or
// quotient bit per cycle, sign fix-up in a final cycle, start/busy/done handshake.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MDStart,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] MDOpX,
  input  logic [WIDTH-1:0] MDOpY,
  output logic             MDBusy,
  output logic             MDDone,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MULT = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mag_q, mag_d;        // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;        // {partial hi, multiplier} or {remainder, dividend/quotient}
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               signed_op, x_neg, y_neg;
  logic [WIDTH-1:0]   x_mag, y_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic               take;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign signed_op = (MDOp == OP_MULT) || (MDOp == OP_DIV);
  assign x_neg     = signed_op & MDOpX[WIDTH-1];
  assign y_neg     = signed_op & MDOpY[WIDTH-1];
  assign x_mag     = x_neg ? -MDOpX : MDOpX;
  assign y_mag     = y_neg ? -MDOpY : MDOpY;

  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right by one.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring division: the quotient bit replaces the dividend bit shifted out.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, mag_q};
  assign take     = ~rem_diff[WIDTH];
  assign div_next = {(take ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], take};

  // With a zero divisor the remainder ends as |X|; restoring the dividend's
  // sign therefore returns the raw X without a separate copy.
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = div0_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    mag_d     = mag_q;
    acc_d     = acc_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (MDStart) begin
          if (!MDOp[2]) begin
            state_d   = S_RUN;
            cnt_d     = '0;
            is_div_d  = MDOp[1];
            neg_res_d = x_neg ^ y_neg;
            neg_rem_d = x_neg;
            div0_d    = MDOp[1] && (MDOpY == '0);
            mag_d     = MDOp[1] ? y_mag : x_mag;
            acc_d     = {{WIDTH{1'b0}}, (MDOp[1] ? x_mag : y_mag)};
          end else if (MDOp == OP_MTHI) begin
            hi_d = MDOpX;
          end else if (MDOp == OP_MTLO) begin
            lo_d = MDOpX;
          end
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: all registers, datapath included, are reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mag_q     <= '0;
      acc_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mag_q     <= mag_d;
      acc_q     <= acc_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign MDBusy = (state_q != S_IDLE);
  assign MDDone = done_q;
  assign HI     = hi_q;
  assign LO     = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv at WIDTH=32 and WIDTH=8, checked against an arithmetic
// model of the MIPS mult/div rules.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        s32, s8;
  logic [2:0]  op32, op8;
  logic [31:0] x32, y32, hi32, lo32;
  logic [7:0]  x8, y8, hi8, lo8;
  logic        busy32, done32, busy8, done8;

  int total = 0;
  int bad   = 0;

  logic [31:0] sh_hi32, sh_lo32;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .MDStart(s32), .MDOp(op32), .MDOpX(x32), .MDOpY(y32),
    .MDBusy(busy32), .MDDone(done32), .HI(hi32), .LO(lo32)
  );

  alu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .MDStart(s8), .MDOp(op8), .MDOpX(x8), .MDOpY(y8),
    .MDBusy(busy8), .MDDone(done8), .HI(hi8), .LO(lo8)
  );

  task automatic set_in(input bit w8, input logic s, input logic [2:0] op,
                        input logic [63:0] x, input logic [63:0] y);
    if (w8) begin
      s8 = s; op8 = op; x8 = x[7:0]; y8 = y[7:0];
    end else begin
      s32 = s; op32 = op; x32 = x[31:0]; y32 = y[31:0];
    end
  endtask

  function automatic logic get_busy(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction

  function automatic logic get_done(input bit w8);
    return w8 ? done8 : done32;
  endfunction

  function automatic logic [63:0] get_hi(input bit w8);
    return w8 ? {56'd0, hi8} : {32'd0, hi32};
  endfunction

  function automatic logic [63:0] get_lo(input bit w8);
    return w8 ? {56'd0, lo8} : {32'd0, lo32};
  endfunction

  function automatic logic [63:0] mask_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference: signed/unsigned 64-bit arithmetic, truncated to the result width.
  function automatic void model(input int w, input logic [2:0] op,
                                input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] hi, output logic [63:0] lo);
    logic [63:0] mask, ux, uy, up;
    longint      sx, sy, sp, t;
    mask = mask_of(w);
    ux = x & mask;
    uy = y & mask;
    t  = longint'(ux << (64 - w));
    sx = t >>> (64 - w);
    t  = longint'(uy << (64 - w));
    sy = t >>> (64 - w);
    hi = '0;
    lo = '0;
    case (op)
      3'd0: begin
        sp = sx * sy;
        up = sp;
        hi = (up >> w) & mask;
        lo = up & mask;
      end
      3'd1: begin
        up = ux * uy;
        hi = (up >> w) & mask;
        lo = up & mask;
      end
      3'd2: begin
        if (uy == 64'd0) begin
          lo = mask; hi = ux;
        end else begin
          sp = sx / sy; up = sp; lo = up & mask;
          sp = sx % sy; up = sp; hi = up & mask;
        end
      end
      3'd3: begin
        if (uy == 64'd0) begin
          lo = mask; hi = ux;
        end else begin
          lo = (ux / uy) & mask;
          hi = (ux % uy) & mask;
        end
      end
      default: begin
        hi = '0; lo = '0;
      end
    endcase
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = mask_of(w);
      2: v = 64'd1 << (w - 1);
      3: v = 64'd1;
      4: v = 64'd7;
      default: v = {$urandom, $urandom} & mask_of(w);
    endcase
    return v;
  endfunction

  // Issues one mult/div op starting in the current cycle and checks busy
  // length, the done pulse and HI/LO. Returns in the MDDone cycle.
  task automatic run_op(input bit w8, input logic [2:0] op, input logic [63:0] x,
                        input logic [63:0] y, input string name);
    logic [63:0] eh, el;
    int w, nb;
    bit early;
    w = w8 ? 8 : 32;
    model(w, op, x, y, eh, el);
    set_in(w8, 1'b1, op, x, y);
    @(posedge clk); #1;
    set_in(w8, 1'b0, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom});
    nb = 0;
    early = 1'b0;
    while (get_busy(w8) && nb < 200) begin
      nb++;
      if (get_done(w8)) early = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (nb !== w + 1) begin
      bad++; $display("FAIL %s busy_cycles: got %0d want %0d", name, nb, w + 1);
    end
    total++;
    if (early !== 1'b0) begin
      bad++; $display("FAIL %s done_while_busy: got %0b want 0", name, early);
    end
    total++;
    if (get_done(w8) !== 1'b1) begin
      bad++; $display("FAIL %s done_pulse: got %b want 1", name, get_done(w8));
    end
    total++;
    if (get_hi(w8) !== eh) begin
      bad++; $display("FAIL %s hi: got %h want %h", name, get_hi(w8), eh);
    end
    total++;
    if (get_lo(w8) !== el) begin
      bad++; $display("FAIL %s lo: got %h want %h", name, get_lo(w8), el);
    end
    if (!w8) begin
      sh_hi32 = eh[31:0];
      sh_lo32 = el[31:0];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    set_in(1'b1, 1'b0, 3'd0, 64'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy32, done32, hi32, lo32} !== 66'd0) begin
      bad++; $display("FAIL reset32: got busy=%b done=%b hi=%h lo=%h want all 0", busy32, done32, hi32, lo32);
    end
    total++;
    if ({busy8, done8, hi8, lo8} !== 18'd0) begin
      bad++; $display("FAIL reset8: got busy=%b done=%b hi=%h lo=%h want all 0", busy8, done8, hi8, lo8);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    bit seen;
    set_in(1'b0, 1'b1, 3'd4, 64'hDEADBEEF, 64'd0);
    @(posedge clk); #1;
    set_in(1'b0, 1'b1, 3'd1, 64'hFFFFFFFF, 64'hFFFFFFFF);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy32, hi32, lo32} !== 65'd0) begin
      bad++; $display("FAIL abort_reset: got busy=%b hi=%h lo=%h want all 0", busy32, hi32, lo32);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32 || busy32) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL abort_no_done: got activity=%b want 0", seen);
    end
    total++;
    if ({hi32, lo32} !== 64'd0) begin
      bad++; $display("FAIL abort_hilo: got hi=%h lo=%h want 0", hi32, lo32);
    end
    sh_hi32 = '0;
    sh_lo32 = '0;
  endtask

  task automatic test_move();
    set_in(1'b0, 1'b1, 3'd4, 64'h12345678, 64'd0);
    @(posedge clk); #1;
    total++;
    if ({busy32, done32, hi32, lo32} !== {2'b00, 32'h12345678, sh_lo32}) begin
      bad++; $display("FAIL mthi: got busy=%b done=%b hi=%h lo=%h want 0 0 12345678 %h", busy32, done32, hi32, lo32, sh_lo32);
    end
    set_in(1'b0, 1'b1, 3'd5, 64'h9ABCDEF0, 64'd0);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    total++;
    if ({busy32, done32, hi32, lo32} !== {2'b00, 32'h12345678, 32'h9ABCDEF0}) begin
      bad++; $display("FAIL mtlo: got busy=%b done=%b hi=%h lo=%h want 0 0 12345678 9abcdef0", busy32, done32, hi32, lo32);
    end
    sh_hi32 = 32'h12345678;
    sh_lo32 = 32'h9ABCDEF0;
    for (int op = 6; op <= 7; op++) begin
      set_in(1'b0, 1'b1, 3'(op), {$urandom, $urandom}, {$urandom, $urandom});
      @(posedge clk); #1;
      set_in(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
      @(posedge clk); #1;
      total++;
      if ({busy32, done32, hi32, lo32} !== {2'b00, sh_hi32, sh_lo32}) begin
        bad++; $display("FAIL noop%0d: got busy=%b done=%b hi=%h lo=%h want 0 0 %h %h", op, busy32, done32, hi32, lo32, sh_hi32, sh_lo32);
      end
    end
  endtask

  task automatic test_directed();
    run_op(1'b0, 3'd1, 64'hFFFFFFFF, 64'hFFFFFFFF, "multu_max");
    total++;
    if ({hi32, lo32} !== 64'hFFFFFFFE_00000001) begin
      bad++; $display("FAIL multu_max_const: got %h_%h want fffffffe_00000001", hi32, lo32);
    end
    // Each following op starts in the MDDone cycle of the previous one.
    run_op(1'b0, 3'd0, 64'hFFFFFFF9, 64'd3, "mult_neg");
    run_op(1'b0, 3'd2, 64'hFFFFFFF9, 64'd2, "div_neg");
    total++;
    if ({hi32, lo32} !== 64'hFFFFFFFF_FFFFFFFD) begin
      bad++; $display("FAIL div_neg_const: got %h_%h want ffffffff_fffffffd", hi32, lo32);
    end
    run_op(1'b0, 3'd2, 64'h80000000, 64'hFFFFFFFF, "div_ovf");
    run_op(1'b0, 3'd3, 64'd5, 64'd0, "divu_zero");
    run_op(1'b0, 3'd2, 64'hFFFFFFF9, 64'd0, "div_zero_neg");
    total++;
    if ({hi32, lo32} !== 64'hFFFFFFF9_FFFFFFFF) begin
      bad++; $display("FAIL div_zero_neg_const: got %h_%h want fffffff9_ffffffff", hi32, lo32);
    end
    @(posedge clk); #1;
    total++;
    if ({busy32, done32} !== 2'b00) begin
      bad++; $display("FAIL done_one_cycle: got busy=%b done=%b want 0 0", busy32, done32);
    end
    run_op(1'b1, 3'd3, 64'd200, 64'd7, "divu8");
    run_op(1'b1, 3'd0, 64'h80, 64'h80, "mult8_minsq");
    run_op(1'b1, 3'd2, 64'h80, 64'hFF, "div8_ovf");
  endtask

  task automatic test_drop_while_busy();
    int nb;
    set_in(1'b1, 1'b1, 3'd3, 64'd200, 64'd7);
    @(posedge clk); #1;
    set_in(1'b1, 1'b0, 3'd0, 64'd0, 64'd0);
    nb = 0;
    while (busy8 && nb < 100) begin
      nb++;
      if (nb == 3) set_in(1'b1, 1'b1, 3'd5, 64'h55, 64'd0);
      else if (nb == 5) set_in(1'b1, 1'b1, 3'd4, 64'hAA, 64'd0);
      else set_in(1'b1, 1'b0, 3'd0, 64'd0, 64'd0);
      @(posedge clk); #1;
    end
    set_in(1'b1, 1'b0, 3'd0, 64'd0, 64'd0);
    total++;
    if (nb !== 9) begin
      bad++; $display("FAIL drop_busy_cycles: got %0d want 9", nb);
    end
    total++;
    if ({done8, hi8, lo8} !== {1'b1, 8'd4, 8'd28}) begin
      bad++; $display("FAIL drop_result: got done=%b hi=%0d lo=%0d want 1 4 28", done8, hi8, lo8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit w8;
      int w;
      w8 = (i % 2) == 1;
      w = w8 ? 8 : 32;
      run_op(w8, 3'($urandom_range(0, 3)), pick(w), pick(w), "random");
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    sh_hi32 = '0;
    sh_lo32 = '0;
    test_reset();
    test_abort();
    test_move();
    test_directed();
    test_drop_while_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Iterative multiply/divide unit for the MIPS datapath. It sits beside the combinational ALU and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO under a start/busy/done handshake, so the pipeline can stall on Busy and later read HI/LO for MFHI/MFLO.
- Generalises the single-cycle ALU: width is a parameter, and operations are multi-cycle and sequential (one product/quotient bit per cycle).

Parameters:
- WIDTH, 32, operand width and HI/LO width; legal range 4..64. The iteration counter width is derived as clog2(WIDTH+1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- MDStart  input  1  request; sampled only in IDLE
- MDOp  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op
- MDOpX  input  WIDTH  multiplicand/dividend (rs); source value for MTHI/MTLO
- MDOpY  input  WIDTH  multiplier/divisor (rt)
- MDBusy  output  1  high while an iterative operation is in flight
- MDDone  output  1  one-cycle pulse when HI/LO take a mult/div result
- HI  output  WIDTH  high product word / remainder
- LO  output  WIDTH  low product word / quotient

Behaviour:
- Clock and reset: single clock domain; reset is asynchronous, active-low. While rst_n=0: state=IDLE, HI=0, LO=0, MDBusy=0, MDDone=0, counter=0, internal accumulators=0.
- Reset asserted mid-operation aborts the operation immediately. Nothing is written to HI/LO and no MDDone pulse is produced.
- States: IDLE, RUN, FIX.
  - IDLE --(MDStart & MDOp in 0..3)--> RUN.
  - RUN --(counter reaches WIDTH)--> FIX.
  - FIX --> IDLE.
- Accept edge (IDLE, MDStart=1, mult/div op):
  - latch operand magnitudes (two's-complement absolute value for MULT/DIV; raw values for MULTU/DIVU);
  - latch the result-sign flags;
  - clear the counter.
- RUN, mult: one shift-add step per cycle, producing a 2*WIDTH-bit unsigned product.
- RUN, div: one restoring shift-subtract step per cycle, producing a WIDTH-bit quotient and remainder.
- RUN lasts exactly WIDTH cycles.
- FIX (1 cycle) applies sign correction:
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign (truncate toward zero).
- Latency: MDBusy is high for exactly WIDTH+1 cycles, starting in the cycle after the accept edge.
  - On the edge leaving FIX, HI/LO are written, MDBusy falls and MDDone goes high for exactly one cycle.
  - New HI/LO values are visible in the MDDone cycle.
- Product mapping: HI = product[2W-1:W], LO = product[W-1:0].
- Quotient mapping: LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU): LO = all ones and HI = MDOpX as latched, raw and with no sign fix. Takes the same WIDTH+1 cycles; no error flag.
- Signed overflow (DIV, most-negative / -1): LO = most-negative value, HI = 0.
- MTHI/MTLO in IDLE: HI (resp. LO) <= MDOpX on the accept edge.
  - MDBusy stays 0 and MDDone stays 0; the other register is unchanged.
  - Back-to-back accepts on consecutive cycles are legal.
- MDOp 6/7 with MDStart: ignored, no state change.
- MDStart while MDBusy=1 (any op, including MTHI/MTLO) is ignored. Requests are not queued; the pipeline must stall on MDBusy.
- MDStart in the MDDone cycle (state IDLE) is accepted normally.
- HI/LO hold their previous values throughout RUN/FIX. Operand input changes after the accept edge have no effect.
- All arithmetic is modulo 2^WIDTH per result word; no X outputs under any legal input.

Test Plan:
- Reset, then pulse rst_n=0 during RUN of a MULTU -> HI=LO=0, MDBusy=0, and no MDDone after release.
- WIDTH=32, MULTU X=0xFFFFFFFF Y=0xFFFFFFFF -> MDBusy high for exactly 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001, MDDone=1 for one cycle.
- WIDTH=32, MULT X=-7 (0xFFFFFFF9) Y=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- WIDTH=32, DIV X=-7 Y=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - DIV X=0x80000000 Y=0xFFFFFFFF -> LO=0x80000000, HI=0.
  - DIVU X=5 Y=0 -> LO=0xFFFFFFFF, HI=5.
- WIDTH=8, DIVU X=200 Y=7 -> LO=28, HI=4, MDBusy for 9 cycles. A second MDStart (MTLO X=0x55) issued mid-operation is dropped: LO=28, not 0x55.
- MTHI X=0x12345678 then MTLO X=0x9ABCDEF0 on consecutive cycles -> HI/LO updated on each accept edge, MDBusy and MDDone stay 0. A MULTU accepted in the cycle MDDone is high starts immediately.
